// File: rtl/uart_mem_loader_pkg.sv
// Shared types and constants for the UART boot loader: FSM state encoding,
// frame sync byte and the small byte-lane / checksum helpers.
package uart_mem_loader_pkg;

  typedef enum logic [3:0] {
    ST_SYNC = 4'd0,
    ST_LEN0 = 4'd1,
    ST_LEN1 = 4'd2,
    ST_LEN2 = 4'd3,
    ST_LEN3 = 4'd4,
    ST_DATA = 4'd5,
    ST_CSUM = 4'd6,
    ST_DONE = 4'd7,
    ST_ERR  = 4'd8
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h5A;

  function automatic logic [3:0] lane_mask(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/uart_mem_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, start-glitch
// rejection and a one-cycle byte_valid strobe with a stop-bit frame_err flag.
module loader_uart_rx
  #(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 115200
  )
  (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
  );

  localparam int P    = CLOCK_RATE / BAUD_RATE;
  localparam int HALF = P / 2;
  localparam int CW   = $clog2(P + 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  logic [1:0]    sync_r;
  logic          rx_prev_r;
  logic          rx_s;
  logic          fell_s;
  rx_state_t     state_r;
  logic [CW-1:0] tick_r;
  logic [2:0]    bit_r;
  logic [7:0]    shift_r;

  assign rx_s   = sync_r[1];
  assign fell_s = rx_prev_r & ~rx_s;

  // Synchroniser and edge-detect history; both reset to the idle-high level
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_r    <= 2'b11;
      rx_prev_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[0], rx};
      rx_prev_r <= sync_r[1];
    end
  end

  // Bit-timing state machine; start bit is re-checked at half a period
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= RX_IDLE;
      tick_r     <= '0;
      bit_r      <= 3'd0;
      shift_r    <= 8'h00;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          tick_r <= '0;
          bit_r  <= 3'd0;
          if (fell_s) begin
            state_r <= RX_START;
          end
        end
        RX_START: begin
          if (tick_r == CW'(HALF - 1)) begin
            tick_r  <= '0;
            state_r <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            tick_r <= tick_r + CW'(1);
          end
        end
        RX_DATA: begin
          if (tick_r == CW'(P - 1)) begin
            tick_r  <= '0;
            shift_r <= {rx_s, shift_r[7:1]};
            bit_r   <= bit_r + 3'd1;
            if (bit_r == 3'd7) begin
              state_r <= RX_STOP;
            end
          end else begin
            tick_r <= tick_r + CW'(1);
          end
        end
        RX_STOP: begin
          if (tick_r == CW'(P - 1)) begin
            tick_r     <= '0;
            byte_valid <= 1'b1;
            byte_data  <= shift_r;
            frame_err  <= ~rx_s;
            state_r    <= RX_IDLE;
          end else begin
            tick_r <= tick_r + CW'(1);
          end
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Boot-time image loader: parses a framed UART image into byte writes and holds
// the core in reset until done. Define LOADER_CHECKSUM_EN for the trailing checksum.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
  #(
    parameter int          CLOCK_RATE = 100_000_000,
    parameter int          BAUD_RATE  = 115200,
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] MAX_BYTES  = 32'he000
  )
  (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx,
    output logic                  mem_write,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    output logic                  mem_wgrubby,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  core_rstn,
    output logic                  loading,
    output logic                  error
  );

  logic          byte_valid;
  logic [7:0]    rx_byte;
  logic          frame_err;
  loader_state_t state_r;
  logic [31:0]   cnt_r;
  logic [31:0]   len_r;
  logic [31:0]   len_full_s;
  logic          last_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    sum_r;
`endif

  loader_uart_rx #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE)
  ) u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (rx_byte),
    .frame_err  (frame_err)
  );

  assign len_full_s  = {rx_byte, len_r[23:0]};
  assign last_s      = (cnt_r == (len_r - 32'd1));
  assign mem_wgrubby = 1'b0;

  // Frame parser and write port; status outputs follow the state one cycle later
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_SYNC;
      cnt_r     <= 32'd0;
      len_r     <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_r     <= 8'h00;
`endif
      mem_write <= 1'b0;
      mem_wmask <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
      mem_addr  <= '0;
      core_rstn <= 1'b0;
      loading   <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      loading   <= (state_r != ST_DONE);
      core_rstn <= (state_r == ST_DONE);
      error     <= (state_r == ST_ERR);
      if (byte_valid) begin
        case (state_r)
          ST_SYNC: begin
            if (!frame_err && (rx_byte == SYNC_BYTE)) begin
              state_r <= ST_LEN0;
              cnt_r   <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
              sum_r   <= 8'h00;
`endif
            end
          end
          ST_LEN0, ST_LEN1, ST_LEN2: begin
            if (frame_err) begin
              state_r <= ST_ERR;
              error   <= 1'b1;
            end else begin
              case (state_r)
                ST_LEN0: begin len_r[7:0]   <= rx_byte; state_r <= ST_LEN1; end
                ST_LEN1: begin len_r[15:8]  <= rx_byte; state_r <= ST_LEN2; end
                ST_LEN2: begin len_r[23:16] <= rx_byte; state_r <= ST_LEN3; end
                default: state_r <= ST_ERR;
              endcase
            end
          end
          ST_LEN3: begin
            len_r <= len_full_s;
            if (frame_err || (len_full_s > MAX_BYTES)) begin
              state_r <= ST_ERR;
              error   <= 1'b1;
            end else if (len_full_s == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_r   <= ST_CSUM;
`else
              state_r   <= ST_DONE;
              core_rstn <= 1'b1;
              loading   <= 1'b0;
`endif
            end else begin
              state_r <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (frame_err) begin
              state_r <= ST_ERR;
              error   <= 1'b1;
            end else begin
              mem_write <= 1'b1;
              mem_addr  <= cnt_r[ADDR_WIDTH+1:2];
              mem_wmask <= lane_mask(cnt_r[1:0]);
              mem_wdata <= {4{rx_byte}};
              cnt_r     <= cnt_r + 32'd1;
`ifdef LOADER_CHECKSUM_EN
              sum_r     <= csum_add(sum_r, rx_byte);
              if (last_s) begin
                state_r <= ST_CSUM;
              end
`else
              if (last_s) begin
                state_r   <= ST_DONE;
                core_rstn <= 1'b1;
                loading   <= 1'b0;
              end
`endif
            end
          end
`ifdef LOADER_CHECKSUM_EN
          ST_CSUM: begin
            // Payload sum plus checksum byte must wrap to zero
            if (!frame_err && (csum_add(sum_r, rx_byte) == 8'h00)) begin
              state_r   <= ST_DONE;
              core_rstn <= 1'b1;
              loading   <= 1'b0;
            end else begin
              state_r <= ST_ERR;
              error   <= 1'b1;
            end
          end
`endif
          ST_DONE, ST_ERR: begin
            state_r <= state_r;
          end
          default: begin
            state_r <= ST_ERR;
            error   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
